// File: rtl/mux_arbiter_pkg.sv
// Shared types and defaults for the two-requester mux arbiter.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package mux_arbiter_pkg;

  localparam int MAX_HOLD_DEFAULT = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    GAP    = 2'd3
  } state_t;

  // One-hot owner of the shared mux for a given arbiter state.
  function automatic logic [1:0] grant_of(input state_t s);
    logic [1:0] g;
    g = 2'b00;
    case (s)
      GRANT0:  g = 2'b01;
      GRANT1:  g = 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/mux2_path.sv
// W-bit 2:1 data mux, forced to zero whenever the output is not valid.
// Latency: combinational from the registered select and the data inputs.
// Backpressure: none; the arbiter decides ownership, this only steers data.
module mux2_path #(
  parameter int W = 1
) (
  input  logic         sel,
  input  logic         valid,
  input  logic [W-1:0] din0,
  input  logic [W-1:0] din1,
  output logic [W-1:0] dout
);

  // Steer the owner's data; idle cycles present all zeros.
  always_comb begin
    dout = '0;
    if (valid) begin
      dout = sel ? din1 : din0;
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin owner arbitration of a shared 2:1 mux with a bounded hold time.
// Latency: grant appears one cycle after req is sampled in IDLE; one GAP cycle after every release.
// Backpressure: an owner held for MAX_HOLD cycles is forced off and blocked until its req drops.
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int W        = 1,
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [1:0]   req,
  input  logic [W-1:0] din0,
  input  logic [W-1:0] din1,
  output logic [1:0]   grant,
  output logic         sel,
  output logic [W-1:0] dout,
  output logic         dout_valid,
  output logic         timeout
);

  localparam int            CW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_HOLD - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [1:0]    block;
  logic [1:0]    block_nxt;
  logic [1:0]    blk_set;
  logic [1:0]    elig;
  logic          sel_nxt;
  logic          last_grant;
  logic          last_nxt;
  logic          owner;
  logic          pick;

  // Next-state, hold counter and forced-release decisions.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = sel;
    last_nxt  = last_grant;
    blk_set   = 2'b00;
    timeout   = 1'b0;
    pick      = 1'b0;
    elig      = req & ~block;
    owner     = (state == GRANT1);

    case (state)
      IDLE: begin
        if (elig != 2'b00) begin
          // On a tie the requester that did not own the mux last time wins.
          pick      = (elig == 2'b11) ? ~last_grant : elig[1];
          state_nxt = pick ? GRANT1 : GRANT0;
          cnt_nxt   = '0;
          sel_nxt   = pick;
          last_nxt  = pick;
        end
      end
      GRANT0, GRANT1: begin
        if (!req[owner]) begin
          // Voluntary release wins even on the final allowed cycle.
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else if (cnt == LAST_CNT) begin
          state_nxt      = GAP;
          cnt_nxt        = '0;
          timeout        = 1'b1;
          blk_set[owner] = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // A dropped request always clears its block; a forced release sets it.
    block_nxt = req & (block | blk_set);
  end

  // State, counter, block flags and the registered select.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      block      <= 2'b00;
      sel        <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      block      <= block_nxt;
      sel        <= sel_nxt;
      last_grant <= last_nxt;
    end
  end

  // Ownership outputs decode directly from the registered state.
  always_comb begin
    grant      = grant_of(state);
    dout_valid = |grant;
  end

  mux2_path #(
    .W(W)
  ) u_path (
    .sel   (sel),
    .valid (dout_valid),
    .din0  (din0),
    .din1  (din1),
    .dout  (dout)
  );

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 SHALL have parameter W, default 1: data width of each mux input and of the output.
REQ-002 SHALL have parameter MAX_HOLD, default 15: maximum consecutive grant cycles per requester; legal range 2..255.
REQ-003 SHALL have port Clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  2  request from requester k on req[k], held high while ownership is wanted.
REQ-006 SHALL have port din0  input  W  data of requester 0.
REQ-007 SHALL have port din1  input  W  data of requester 1.
REQ-008 SHALL have port grant  output  2  one-hot owner of the shared mux; 00 when nobody owns it.
REQ-009 SHALL have port sel  output  1  registered mux select: 0 = din0, 1 = din1.
REQ-010 SHALL have port dout  output  W  selected data; all zeros when dout_valid is 0.
REQ-011 SHALL have port dout_valid  output  1  high exactly when grant is nonzero.
REQ-012 SHALL have port timeout  output  1  one-cycle pulse on a forced release.

Function
REQ-013 SHALL implement the states IDLE, GRANT0, GRANT1 and GAP.
REQ-014 SHALL, in IDLE, evaluate the eligible requests: req[k]=1 and block[k]=0.
REQ-015 SHALL, with exactly one eligible request in IDLE, enter GRANTk next cycle, so grant is visible one cycle after req is sampled.
REQ-016 SHALL, with both requests eligible in IDLE, grant the requester other than last_grant (round-robin).
REQ-017 SHALL, in GRANTk, drive grant = one-hot k, sel = k, dout = dink (combinational from registered sel), dout_valid = 1.
REQ-018 SHALL increment the hold counter every GRANTk cycle, starting at 0 on entry; counter width is ceil(log2(MAX_HOLD)).
REQ-019 SHALL leave GRANTk for GAP when sampled req[k]=0; grant ends on the following edge.
REQ-020 SHALL, when the counter equals MAX_HOLD-1 and req[k] is still 1, leave for GAP, pulse timeout for that cycle and set block[k]; grant therefore lasts exactly MAX_HOLD cycles.
REQ-021 SHALL clear block[k] on any cycle in which req[k]=0, in any state.
REQ-022 SHALL stay in GAP for exactly one cycle with grant=00, dout_valid=0 and dout=0, then enter IDLE; consecutive grants are separated by at least 2 idle cycles.
REQ-023 SHALL update last_grant to k on entry to GRANTk.
REQ-024 SHALL hold sel at its last value outside GRANT states.
REQ-025 SHALL ignore changes of the non-owner's req during a grant; it is considered only in IDLE.
REQ-026 SHALL, when req[k] falls on the same cycle the counter reaches MAX_HOLD-1, treat it as a normal release: no timeout and no block.

Reset
REQ-027 SHALL, on Reset=1 at a clock edge, enter IDLE with grant=00, sel=0, dout_valid=0, dout=0, timeout=0, counter=0, block=00 and last_grant=1 (requester 0 wins the first tie).
REQ-028 SHALL let Reset take priority over every transition, including mid-grant and in GAP; outputs are reset values on the cycle after the edge.

Structure
REQ-029 SHALL place the state enumeration and the MAX_HOLD default in shared package mux_arbiter_pkg.
REQ-030 SHALL place the data path in a sub-module mux2_path (W-bit 2:1 mux gated by dout_valid); the FSM, counter and block flags stay in mux_arbiter.

Verification
REQ-031 SHALL cover: reset, then req=01, din0=1 -> grant=01, sel=0, dout=1, dout_valid=1 one cycle later.
REQ-032 SHALL cover: req=11 straight after reset -> grant=01; drop req[0] -> GAP, IDLE, then grant=10.
REQ-033 SHALL cover: req[0] held 20 cycles -> grant=01 for exactly 15 cycles, timeout pulses once, no regrant until req[0] falls and rises.
REQ-034 SHALL cover: Reset=1 during GRANT1 -> next cycle grant=00, dout_valid=0, sel=0, then req=11 grants requester 0.
REQ-035 SHALL cover: W=4, req=10, din1=4'hA -> dout=4'hA while granted, dout=0 in GAP.
